morse_encoder: RTL and testbench

- Transmit-side counterpart of the Morse receiver: accepts one character code at a time and emits timed on/off keying on `key_out`.
- Also emits symbol strobes on `sym_out` in the receiver's 2-bit symbol encoding: 01 dot, 11 dash, 10 letter terminate, 00 idle.
- Sits between a character source (keypad/UART/test driver) and the keying line or the receiver input, so a loopback path exists.

---
 rtl/morse_pkg.sv | 42 ++++
 rtl/morse_rom.sv | 53 +++++
 rtl/morse_encoder.sv | 144 ++++++++++++++
 tb/tb_morse_encoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse types: FSM states, 2-bit symbol codes, character codes and the ROM entry layout.
// ROM patterns are left-aligned: symbol i of a letter is pattern[4-i], and 1 = dash.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MARK  = 3'd1,
    ST_SPACE = 3'd2,
`ifdef MORSE_WORD_GAP_EN
    ST_LGAP  = 3'd3,
    ST_WGAP  = 3'd4
`else
    ST_LGAP  = 3'd3
`endif
  } state_t;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b11;
  localparam logic [1:0] SYM_TERM = 2'b10;

  localparam logic [5:0] CODE_A          = 6'd0;
  localparam logic [5:0] CODE_Z          = 6'd25;
  localparam logic [5:0] CODE_DIGIT0     = 6'd26;
  localparam logic [5:0] CODE_DIGIT9     = 6'd35;
  localparam logic [5:0] CODE_WORD_SPACE = 6'd63;

  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pattern;
  } rom_entry_t;

  function automatic rom_entry_t mk_entry(input logic [2:0] len, input logic [4:0] pattern);
    rom_entry_t e;
    e.valid   = 1'b1;
    e.len     = len;
    e.pattern = pattern;
    return e;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Character code to Morse length/pattern lookup; purely combinational, zero latency.
// No flow control: the entry follows char_in directly; unknown codes give valid = 0.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] char_in,
  output rom_entry_t entry
);

  always_comb begin
    entry = '0;
    case (char_in)
      6'd0:  entry = mk_entry(3'd2, 5'b01000); // A
      6'd1:  entry = mk_entry(3'd4, 5'b10000);
      6'd2:  entry = mk_entry(3'd4, 5'b10100);
      6'd3:  entry = mk_entry(3'd3, 5'b10000);
      6'd4:  entry = mk_entry(3'd1, 5'b00000);
      6'd5:  entry = mk_entry(3'd4, 5'b00100);
      6'd6:  entry = mk_entry(3'd3, 5'b11000);
      6'd7:  entry = mk_entry(3'd4, 5'b00000);
      6'd8:  entry = mk_entry(3'd2, 5'b00000);
      6'd9:  entry = mk_entry(3'd4, 5'b01110);
      6'd10: entry = mk_entry(3'd3, 5'b10100);
      6'd11: entry = mk_entry(3'd4, 5'b01000);
      6'd12: entry = mk_entry(3'd2, 5'b11000);
      6'd13: entry = mk_entry(3'd2, 5'b10000);
      6'd14: entry = mk_entry(3'd3, 5'b11100);
      6'd15: entry = mk_entry(3'd4, 5'b01100);
      6'd16: entry = mk_entry(3'd4, 5'b11010);
      6'd17: entry = mk_entry(3'd3, 5'b01000);
      6'd18: entry = mk_entry(3'd3, 5'b00000);
      6'd19: entry = mk_entry(3'd1, 5'b10000);
      6'd20: entry = mk_entry(3'd3, 5'b00100);
      6'd21: entry = mk_entry(3'd4, 5'b00010);
      6'd22: entry = mk_entry(3'd3, 5'b01100);
      6'd23: entry = mk_entry(3'd4, 5'b10010);
      6'd24: entry = mk_entry(3'd4, 5'b10110);
      6'd25: entry = mk_entry(3'd4, 5'b11000);
      6'd26: entry = mk_entry(3'd5, 5'b11111); // digit 0
      6'd27: entry = mk_entry(3'd5, 5'b01111);
      6'd28: entry = mk_entry(3'd5, 5'b00111);
      6'd29: entry = mk_entry(3'd5, 5'b00011);
      6'd30: entry = mk_entry(3'd5, 5'b00001);
      6'd31: entry = mk_entry(3'd5, 5'b00000);
      6'd32: entry = mk_entry(3'd5, 5'b10000);
      6'd33: entry = mk_entry(3'd5, 5'b11000);
      6'd34: entry = mk_entry(3'd5, 5'b11100);
      6'd35: entry = mk_entry(3'd5, 5'b11110);
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: one char per valid/ready transfer, keying starts the cycle after transfer; MORSE_WORD_GAP_EN adds code 63 = word space.
// Backpressure: char_ready only in IDLE; char_in is ignored while busy and the source must hold valid until ready.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic [1:0] sym_out,
  output logic       busy,
  output logic       err
);

`ifdef MORSE_WORD_GAP_EN
  // The word gap is the longest interval, so it sets the counter width.
  localparam int CNT_W = $clog2(4*UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LD_4U = CNT_W'(4*UNIT_CYCLES - 1);
`else
  localparam int CNT_W = $clog2(3*UNIT_CYCLES + 1);
`endif
  localparam logic [CNT_W-1:0] LD_1U = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_3U = CNT_W'(3*UNIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d, idx_inc;
  logic [2:0]       len_q, len_d;
  logic [4:0]       pat_q, pat_d;
  logic             key_d, err_d;
  logic [1:0]       sym_d;
  logic             xfer, nxt_dash;
  rom_entry_t       rom;

  morse_rom u_rom (
    .char_in (char_in),
    .entry   (rom)
  );

  assign char_ready = (state_q == ST_IDLE);
  assign busy       = ~char_ready;
  assign xfer       = char_valid & char_ready;
  assign idx_inc    = idx_q + 3'd1;
  assign nxt_dash   = pat_q[3'd4 - idx_inc];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;
    key_d   = 1'b0;
    sym_d   = SYM_IDLE;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          len_d = rom.len;
          pat_d = rom.pattern;
          idx_d = 3'd0;
          if (rom.valid) begin
            state_d = ST_MARK;
            key_d   = 1'b1;
            sym_d   = rom.pattern[4] ? SYM_DASH : SYM_DOT;
            cnt_d   = rom.pattern[4] ? LD_3U : LD_1U;
          end
`ifdef MORSE_WORD_GAP_EN
          else if (char_in == CODE_WORD_SPACE) begin
            state_d = ST_WGAP;
            cnt_d   = LD_4U;
          end
`endif
          else begin
            err_d = 1'b1;
          end
        end
      end
      ST_MARK: begin
        if (cnt_q == '0) begin
          if (idx_q != len_q - 3'd1) begin
            state_d = ST_SPACE;
            cnt_d   = LD_1U;
          end else begin
            state_d = ST_LGAP;
            cnt_d   = LD_3U;
            sym_d   = SYM_TERM;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          key_d = 1'b1;
        end
      end
      ST_SPACE: begin
        if (cnt_q == '0) begin
          state_d = ST_MARK;
          idx_d   = idx_inc;
          key_d   = 1'b1;
          sym_d   = nxt_dash ? SYM_DASH : SYM_DOT;
          cnt_d   = nxt_dash ? LD_3U : LD_1U;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef MORSE_WORD_GAP_EN
      ST_WGAP,
`endif
      ST_LGAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      key_out <= 1'b0;
      sym_out <= SYM_IDLE;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      key_out <= key_d;
      sym_out <= sym_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: directed and random characters checked cycle by cycle against
// a waveform built from the dot/dash strings of each character.
module tb_morse_encoder;
  import morse_pkg::*;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       key_out;
  logic [1:0] sym_out;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .key_out    (key_out),
    .sym_out    (sym_out),
    .busy       (busy),
    .err        (err)
  );

  typedef struct packed {
    logic       key;
    logic [1:0] sym;
    logic       err;
    logic       busy;
    logic       rdy;
  } obs_t;

  localparam obs_t IDLE_OBS = 6'b0_00_0_0_1;
  localparam obs_t ERR_OBS  = 6'b0_00_1_0_1;

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];

  string morse_tbl[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic obs_t observe();
    return obs_t'({key_out, sym_out, err, busy, char_ready});
  endfunction

  function automatic void push_n(input int n, input logic key, input logic [1:0] first_sym);
    for (int c = 0; c < n; c++) begin
      obs_t o;
      o.key  = key;
      o.sym  = (c == 0) ? first_sym : 2'b00;
      o.err  = 1'b0;
      o.busy = 1'b1;
      o.rdy  = 1'b0;
      exp_q.push_back(o);
    end
  endfunction

  // Expected per-cycle outputs after the accepting edge; returns expected busy cycles.
  function automatic int expect_char(input logic [5:0] code);
    string s;
    int    units = 0;
    bit    word_gap = 1'b0;
`ifdef MORSE_WORD_GAP_EN
    word_gap = 1'b1;
`endif
    if (code < 6'd36) begin
      s = morse_tbl[code];
      for (int i = 0; i < s.len(); i++) begin
        bit dash = (s[i] == "-");
        units += dash ? 3 : 1;
        push_n((dash ? 3 : 1) * U, 1'b1, dash ? 2'b11 : 2'b01);
        if (i < s.len() - 1) push_n(U, 1'b0, 2'b00);
      end
      push_n(3 * U, 1'b0, 2'b10);
      return U * (units + s.len() - 1 + 3);
    end else if (word_gap && code == 6'd63) begin
      push_n(4 * U, 1'b0, 2'b00);
      return 4 * U;
    end
    exp_q.push_back(ERR_OBS);
    return 0;
  endfunction

  task automatic send(input logic [5:0] code, input bit hold_next, input logic [5:0] next_code,
                      input int abort_at);
    int n;
    int want_busy;
    int busy_seen = 0;
    @(negedge clk);
    check($sformatf("idle_before_c%0d", code), 32'(observe()), 32'(IDLE_OBS));
    char_valid = 1'b1;
    char_in    = code;
    exp_q.delete();
    want_busy = expect_char(code);
    n = exp_q.size();
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      obs_t e = exp_q.pop_front();
      @(negedge clk);
      check($sformatf("c%0d_cyc%0d", code, k), 32'(observe()), 32'(e));
      if (busy) busy_seen++;
      if (k == abort_at) begin
        rst        = 1'b1;
        char_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("abort_c%0d", code), 32'(observe()), 32'(IDLE_OBS));
        rst = 1'b0;
        return;
      end
      if (!e.rdy) begin
        if (hold_next) begin
          char_valid = 1'b1;
          char_in    = next_code;
        end else begin
          char_valid = 1'($urandom_range(0, 1));
          char_in    = 6'($urandom_range(0, 63));
        end
      end else begin
        char_valid = 1'b0;
      end
    end
    check($sformatf("busy_len_c%0d", code), 32'(busy_seen), 32'(want_busy));
  endtask

  function automatic logic [5:0] rand_code();
    if ($urandom_range(0, 3) == 0) return 6'($urandom_range(36, 63));
    return 6'($urandom_range(0, 35));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] cur, nxt;
    bit         hold;
    rst        = 1'b1;
    char_valid = 1'b0;
    char_in    = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(observe()), 32'(IDLE_OBS));
    rst = 1'b0;

    send(6'd4,  1'b0, 6'd0,  0);   // E
    send(6'd0,  1'b0, 6'd0,  0);   // A
    send(6'd26, 1'b1, 6'd19, 0);   // digit 0, valid held into T
    send(6'd19, 1'b0, 6'd0,  0);   // T
    send(6'd40, 1'b0, 6'd0,  0);   // invalid
    send(6'd19, 1'b0, 6'd0,  6);   // T aborted by reset
    send(6'd4,  1'b0, 6'd0,  0);   // E after reset
    send(6'd63, 1'b0, 6'd0,  0);   // word space or invalid

    cur = rand_code();
    for (int i = 0; i < 30; i++) begin
      nxt  = rand_code();
      hold = ($urandom_range(0, 3) == 0);
      send(cur, hold, nxt, 0);
      cur = nxt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
